// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline memory-port arbiter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int DEFAULT_MEM_LAT = 2;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access latency counter: load on issue, count down to zero, flag zero.
module mem_lat_counter #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] load_val,
  output logic             zero
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between IF and MEM stages.
// Handshake: a requester holds its request until its 1-cycle ack; ack and rdata are valid together.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = DEFAULT_MEM_LAT,
  parameter int LAT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [1:0]        dbg_state
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic dm_pend;
  logic grant_dm;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  assign dm_pend = dm_rd | dm_wr;

  mem_lat_counter #(
    .LAT_W (LAT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT_LOAD),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    grant_dm     = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_pend || if_req) begin
          // On a tie the side that did not win last time goes first.
          if (dm_pend && if_req) begin
            grant_dm = (last_grant_q == GNT_IF);
          end else begin
            grant_dm = dm_pend;
          end
          mem_en_d = 1'b1;
          cnt_load = 1'b1;
          if (grant_dm) begin
            state_d      = BUSY_D;
            last_grant_d = GNT_DM;
            mem_we_d     = dm_wr;
            mem_addr_d   = dm_addr;
            mem_wdata_d  = dm_wdata;
          end else begin
            state_d      = BUSY_I;
            last_grant_d = GNT_IF;
            mem_we_d     = 1'b0;
            mem_addr_d   = if_addr;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // Return to IDLE after the ack cycle; the held request is re-arbitrated there.
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_ack    = (state_q == BUSY_I) && cnt_zero;
  assign dm_ack    = (state_q == BUSY_D) && cnt_zero;
  assign if_rdata  = if_ack ? mem_rdata : '0;
  assign dm_rdata  = (dm_ack && !mem_we_q) ? mem_rdata : '0;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Stalls track the live request so a flushed requester un-stalls at once.
  assign stall_if  = rst & if_req & ~if_ack;
  assign stall_mem = rst & dm_pend & ~dm_ack;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected events queued at stimulus time, popped by a monitor.
module tb_mem_port_arbiter;
  import cpu_pkg::*;

  localparam int REC_W = 83;
  localparam logic [1:0] K_ISSUE = 2'd0;
  localparam logic [1:0] K_IFACK = 2'd1;
  localparam logic [1:0] K_DMACK = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic [1:0]  dbg_state;

  logic [15:0] cyc = '0;
  logic        en_d1 = 1'b0;
  logic        en_d2 = 1'b0;
  logic [31:0] addr_d1 = '0;
  logic [31:0] addr_d2 = '0;

  logic [REC_W-1:0] exp_q[$];
  int total = 0;
  int passed = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .dbg_state (dbg_state)
  );

  // clock / cycle stamp / 2-cycle memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 16'd1;
    en_d1   <= mem_en;
    addr_d1 <= mem_addr;
    en_d2   <= en_d1;
    addr_d2 <= addr_d1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00400000: return 32'h8C080004;
      32'h10010004: return 32'h12345678;
      default:      return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  assign mem_rdata = en_d2 ? mem_word(addr_d2) : 32'hBAD0BAD0;

  function automatic logic [REC_W-1:0] mk(input logic [1:0] kind, input logic [15:0] c,
                                          input logic we, input logic [31:0] a, input logic [31:0] d);
    return {kind, c, we, a, d};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: one event per cycle at most (issue, if_ack or dm_ack)
  task automatic monitor();
    logic [REC_W-1:0] obs;
    int n;
    forever begin
      @(negedge clk);
      if (rst) begin
        n = int'(mem_en) + int'(if_ack) + int'(dm_ack);
        if (n > 1) begin
          total++;
          $display("FAIL overlap_c%0d: got %0d events expected 1", cyc, n);
        end
        if (n > 0) begin
          if (mem_en) obs = mk(K_ISSUE, cyc, mem_we, mem_addr, mem_we ? mem_wdata : 32'h0);
          else if (if_ack) obs = mk(K_IFACK, cyc, 1'b0, 32'h0, if_rdata);
          else obs = mk(K_DMACK, cyc, 1'b0, 32'h0, dm_rdata);
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_event_c%0d: got %h expected none", cyc, obs);
          end else begin
            chk($sformatf("event_c%0d", cyc), {13'd0, obs}, {13'd0, exp_q.pop_front()});
          end
        end
      end
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic run_single(input logic is_if, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata, input string name);
    logic [15:0] t0;
    logic        exp_we;
    tick();
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      dm_rd = rd; dm_wr = wr; dm_addr = addr; dm_wdata = wdata;
    end
    t0 = cyc;
    exp_we = !is_if && wr;
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd1, exp_we, addr, exp_we ? wdata : 32'h0));
    exp_q.push_back(mk(is_if ? K_IFACK : K_DMACK, t0 + 16'd3, 1'b0, 32'h0,
                       exp_we ? 32'h0 : mem_word(addr)));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      chk($sformatf("%s_stall_T%0d", name, k), {95'd0, is_if ? stall_if : stall_mem}, {95'd0, k < 3});
    end
    tick();
    clear_inputs();
    @(negedge clk);
    chk($sformatf("%s_idle_T4", name), {94'd0, dbg_state}, {94'd0, IDLE});
  endtask

  initial begin
    logic [15:0] t0;
    rst = 1'b0;
    clear_inputs();
    fork
      monitor();
    join_none

    // reset state, with requests up so forced-low stalls are visible
    #3;
    if_req = 1'b1; dm_rd = 1'b1;
    #1;
    chk("rst_stall_if", {95'd0, stall_if}, 96'd0);
    chk("rst_stall_mem", {95'd0, stall_mem}, 96'd0);
    chk("rst_mem_en", {95'd0, mem_en}, 96'd0);
    chk("rst_acks", {94'd0, if_ack, dm_ack}, 96'd0);
    chk("rst_state", {94'd0, dbg_state}, {94'd0, IDLE});
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) tick();

    // fetch only
    run_single(1'b1, 1'b0, 1'b0, 32'h00400000, 32'h0, "fetch");

    // round robin: both sides requesting continuously, last grant was IF
    tick();
    dm_rd = 1'b1; dm_addr = 32'h10010000;
    if_req = 1'b1; if_addr = 32'h00400000;
    t0 = cyc;
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd1, 1'b0, 32'h10010000, 32'h0));
    exp_q.push_back(mk(K_DMACK, t0 + 16'd3, 1'b0, 32'h0, mem_word(32'h10010000)));
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd5, 1'b0, 32'h00400000, 32'h0));
    exp_q.push_back(mk(K_IFACK, t0 + 16'd7, 1'b0, 32'h0, 32'h8C080004));
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd9, 1'b0, 32'h10010004, 32'h0));
    exp_q.push_back(mk(K_DMACK, t0 + 16'd11, 1'b0, 32'h0, 32'h12345678));
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd13, 1'b0, 32'h00400004, 32'h0));
    exp_q.push_back(mk(K_IFACK, t0 + 16'd15, 1'b0, 32'h0, mem_word(32'h00400004)));
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      if (k == 4) dm_addr = 32'h10010004;
      if (k == 8) if_addr = 32'h00400004;
      @(negedge clk);
      if (k == 7) chk("rr_if_wait_T7", {95'd0, stall_if}, 96'd0);
      if (k == 11) chk("rr_dm_wait_T11", {95'd0, stall_mem}, 96'd0);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    chk("rr_idle", {94'd0, dbg_state}, {94'd0, IDLE});

    // tie with last grant IF: data first, fetch after turnaround
    tick();
    if_req = 1'b1; if_addr = 32'h00400008;
    dm_rd = 1'b1; dm_addr = 32'h10010004;
    t0 = cyc;
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd1, 1'b0, 32'h10010004, 32'h0));
    exp_q.push_back(mk(K_DMACK, t0 + 16'd3, 1'b0, 32'h0, 32'h12345678));
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd5, 1'b0, 32'h00400008, 32'h0));
    exp_q.push_back(mk(K_IFACK, t0 + 16'd7, 1'b0, 32'h0, 32'hA5E5A5AD));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      if (k == 4) dm_rd = 1'b0;
      @(negedge clk);
      chk($sformatf("tie_stall_mem_T%0d", k), {95'd0, stall_mem}, {95'd0, k < 3});
      chk($sformatf("tie_stall_if_T%0d", k), {95'd0, stall_if}, {95'd0, k < 7});
      if (k == 4) chk("tie_idle_T4", {94'd0, dbg_state}, {94'd0, IDLE});
    end
    tick();
    clear_inputs();

    // stores: plain write, then rd+wr treated as write
    run_single(1'b0, 1'b0, 1'b1, 32'h10010000, 32'hDEADBEEF, "store");
    run_single(1'b0, 1'b1, 1'b1, 32'h10010008, 32'h0BADF00D, "rdwr");

    // reset in the middle of a fetch
    tick();
    if_req = 1'b1; if_addr = 32'h00400010;
    t0 = cyc;
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd1, 1'b0, 32'h00400010, 32'h0));
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_mem", {62'd0, mem_en, mem_we, mem_addr}, 96'd0);
    chk("mid_rst_wdata", {64'd0, mem_wdata}, 96'd0);
    chk("mid_rst_acks", {92'd0, if_ack, dm_ack, stall_if, stall_mem}, 96'd0);
    chk("mid_rst_rdata", {32'd0, if_rdata, dm_rdata}, 96'd0);
    chk("mid_rst_state", {94'd0, dbg_state}, {94'd0, IDLE});
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (5) tick();
    run_single(1'b1, 1'b0, 1'b0, 32'h00400014, 32'h0, "post_rst");

    // flush: fetch request dropped while busy
    tick();
    if_req = 1'b1; if_addr = 32'h00400020;
    t0 = cyc;
    exp_q.push_back(mk(K_ISSUE, t0 + 16'd1, 1'b0, 32'h00400020, 32'h0));
    exp_q.push_back(mk(K_IFACK, t0 + 16'd3, 1'b0, 32'h0, mem_word(32'h00400020)));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (k == 2) if_req = 1'b0;
      @(negedge clk);
      if (k < 4) chk($sformatf("flush_stall_T%0d", k), {95'd0, stall_if}, {95'd0, k < 2});
      else chk("flush_idle_T4", {94'd0, dbg_state}, {94'd0, IDLE});
    end
    clear_inputs();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 96'(exp_q.size()), 96'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
